// File: rtl/fpu_arb_pkg.sv
// Shared constants and types for the FP adder arbiter slice.
// The tag ID is sized for the largest requester count so one struct serves every build.
package fpu_arb_pkg;

   localparam int FP_W     = 32;
   localparam int SIGN_BIT = 31;
   localparam int MAX_REQ  = 8;

   function automatic int id_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

   localparam int ID_W = id_w(MAX_REQ);

   typedef struct packed {
      logic            vld;
      logic [ID_W-1:0] id;
   } arb_tag_t;

endpackage

// File: rtl/fpu_add_arbiter_rr.sv
// Round-robin arbiter: the search starts at the rotating pointer and wraps modulo N.
// The pointer moves past the winner only when the grant is taken.
module rr_arbiter
   import fpu_arb_pkg::*;
#(
   parameter int N = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N-1:0]          req,
   input  logic                  advance,
   output logic [N-1:0]          grant,
   output logic [id_w(N)-1:0]    grant_idx,
   output logic                  any
);

   localparam int IW = id_w(N);

   logic [IW-1:0] ptr;
   int            j;

   // Descending scan so the candidate closest to ptr is written last and wins.
   always_comb begin
      grant_idx = '0;
      any       = 1'b0;
      j         = 0;
      for (int k = N - 1; k >= 0; k--) begin
         j = (int'(ptr) + k) % N;
         if (req[j]) begin
            grant_idx = IW'(j);
            any       = 1'b1;
         end
      end
   end

   assign grant = any ? (N'(1) << grant_idx) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (advance && any) begin
         ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + IW'(1);
      end
   end

endmodule

// File: rtl/fpu_add_arbiter.sv
// Shares one fixed-latency pipelined FP adder among N_REQ requesters.
// Subtraction is folded into the issue stage by flipping operand B's sign bit.
module fpu_add_arbiter #(
   parameter int N_REQ   = 4,
   parameter int ADD_LAT = 3,
   parameter int FP_W    = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req_valid,
   output logic [N_REQ-1:0]        req_ready,
   input  logic [N_REQ*FP_W-1:0]   req_a,
   input  logic [N_REQ*FP_W-1:0]   req_b,
   input  logic [N_REQ-1:0]        req_sub,
   output logic                    add_valid,
   output logic [FP_W-1:0]         add_a,
   output logic [FP_W-1:0]         add_b,
   input  logic [FP_W-1:0]         add_res,
   output logic [N_REQ-1:0]        rsp_valid,
   output logic [FP_W-1:0]         rsp_data,
   output logic                    busy
);

   import fpu_arb_pkg::*;

   localparam int IW = id_w(N_REQ);

   logic [N_REQ-1:0] grant;
   logic [IW-1:0]    grant_idx;
   logic             any;
   logic [FP_W-1:0]  sel_a;
   logic [FP_W-1:0]  sel_b;
   logic             sel_sub;
   logic [ID_W-1:0]  iss_id;
   arb_tag_t         tag_q [ADD_LAT];
   arb_tag_t         tag_last;
   logic             tag_busy;

   // The adder never stalls, so every grant is accepted in the cycle it is offered.
   rr_arbiter #(.N(N_REQ)) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req_valid),
      .advance   (any),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any       (any)
   );

   assign req_ready = grant;
   assign sel_a     = req_a[int'(grant_idx) * FP_W +: FP_W];
   assign sel_b     = req_b[int'(grant_idx) * FP_W +: FP_W];
   assign sel_sub   = req_sub[grant_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         add_valid <= 1'b0;
         add_a     <= '0;
         add_b     <= '0;
         iss_id    <= '0;
      end else begin
         add_valid <= any;
         if (any) begin
            add_a  <= sel_a;
            add_b  <= {sel_b[FP_W-1] ^ sel_sub, sel_b[FP_W-2:0]};
            iss_id <= ID_W'(grant_idx);
         end
      end
   end

   // Tag stage ADD_LAT-1 lines up with add_res for the same issue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < ADD_LAT; k++) tag_q[k] <= '0;
      end else begin
         tag_q[0] <= {add_valid, iss_id};
         for (int k = 1; k < ADD_LAT; k++) tag_q[k] <= tag_q[k-1];
      end
   end

   assign tag_last = tag_q[ADD_LAT-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= '0;
         rsp_data  <= '0;
      end else if (tag_last.vld) begin
         rsp_valid <= N_REQ'(1) << tag_last.id;
         rsp_data  <= add_res;
      end else begin
         rsp_valid <= '0;
      end
   end

   always_comb begin
      tag_busy = 1'b0;
      for (int k = 0; k < ADD_LAT; k++) tag_busy = tag_busy | tag_q[k].vld;
   end

   assign busy = add_valid | tag_busy | (|rsp_valid);

endmodule

// File: tb/tb_fpu_add_arbiter.sv
// Bench for fpu_add_arbiter: a behavioural adder stub plus an operation-level model
// (queue of accepted ops with their due cycles) compared against the DUT every cycle.
module tb_fpu_add_arbiter;

   localparam int N   = 4;
   localparam int LAT = 3;
   localparam int W   = 32;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [N-1:0]   req_sub = '0;
   logic [N*W-1:0] req_a = '0;
   logic [N*W-1:0] req_b = '0;
   logic [N-1:0]   req_ready;
   logic [N-1:0]   rsp_valid;
   logic           add_valid;
   logic           busy;
   logic [W-1:0]   add_a, add_b, add_res, rsp_data;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   fpu_add_arbiter #(.N_REQ(N), .ADD_LAT(LAT), .FP_W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_sub   (req_sub),
      .add_valid (add_valid),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_res   (add_res),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .busy      (busy)
   );

   // Single-precision value helpers (normal numbers; tiny/huge results flush/saturate).
   function automatic real sp2r(input logic [31:0] x);
      logic [63:0] d;
      if (x[30:23] == 8'd0) return 0.0;
      d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] r2sp(input real r);
      logic [63:0] d;
      int e;
      d = $realtobits(r);
      e = int'(d[62:52]) - 896;
      if (d[62:0] == 63'd0 || e <= 0) return {d[63], 31'd0};
      if (e >= 255) return {d[63], 8'hFF, 23'd0};
      return {d[63], 8'(e), d[51:29]};
   endfunction

   function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
      return r2sp(sp2r(a) + sp2r(b));
   endfunction

   function automatic logic [31:0] rnd_fp();
      return {1'($urandom), 8'($urandom_range(110, 140)), 23'($urandom)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Adder stub: result of the operands seen in cycle c appears in cycle c+LAT.
   logic [W-1:0] pipe [LAT];
   always @(posedge clk) begin
      pipe[0] <= add_valid ? fadd(add_a, add_b) : $urandom;
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
   end
   assign add_res = pipe[LAT-1];

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          t;
      int          id;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
   } op_t;

   op_t          q[$];
   int           mptr = 0;
   logic [W-1:0] e_a = '0, e_b = '0, e_rd = '0;

   // Model: accepted in cycle t -> issue in t+1, response in t+LAT+2, busy for t+1..t+LAT+2.
   always @(negedge clk) begin
      logic [N-1:0] e_ready, e_rv;
      logic         e_av, e_busy;
      int           g, j;
      op_t          op;
      e_ready = '0; e_rv = '0; e_av = 1'b0; e_busy = 1'b0; g = -1;
      if (!rst_n) begin
         q.delete();
         mptr = 0; e_a = '0; e_b = '0; e_rd = '0;
      end else begin
         while (q.size() > 0 && q[0].t + LAT + 2 < cyc) void'(q.pop_front());
         for (int k = 0; k < N; k++) begin
            j = (mptr + k) % N;
            if (g < 0 && req_valid[j]) g = j;
         end
         if (g >= 0) e_ready[g] = 1'b1;
         foreach (q[i]) begin
            if (q[i].t + 1 == cyc) begin
               e_av = 1'b1; e_a = q[i].a; e_b = q[i].b;
            end
            if (q[i].t + LAT + 2 == cyc) begin
               e_rv = N'(1) << q[i].id; e_rd = q[i].res;
            end
            if (q[i].t < cyc && cyc <= q[i].t + LAT + 2) e_busy = 1'b1;
         end
      end
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("add_valid", 32'(add_valid), 32'(e_av));
      chk("add_a", add_a, e_a);
      chk("add_b", add_b, e_b);
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      chk("rsp_data", rsp_data, e_rd);
      chk("busy", 32'(busy), 32'(e_busy));
      if (rst_n && g >= 0) begin
         op.t   = cyc;
         op.id  = g;
         op.a   = req_a[g*W +: W];
         op.b   = {req_b[g*W + W - 1] ^ req_sub[g], req_b[g*W +: W-1]};
         op.res = r2sp(sp2r(op.a) + (req_sub[g] ? -sp2r(req_b[g*W +: W]) : sp2r(req_b[g*W +: W])));
         q.push_back(op);
         mptr = (g + 1) % N;
      end
   end

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
      req_sub[i]      = s;
   endtask

   initial begin
      chk("model_pin_1p2", fadd(32'h3F800000, 32'h40000000), 32'h40400000);
      chk("model_pin_3m1", fadd(32'h40400000, 32'hBF800000), 32'h40000000);
      repeat (3) next_cyc();
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      next_cyc();
      rst_n = 1'b1;
      next_cyc();

      // Single add from requester 0.
      set_req(0, 32'h3F800000, 32'h40000000, 1'b0);
      req_valid = 4'b0001;
      @(negedge clk) chk("add_ready", 32'(req_ready), 32'h1);
      next_cyc();
      req_valid = '0;
      @(negedge clk);
      chk("add_issue_v", 32'(add_valid), 32'h1);
      chk("add_issue_b", add_b, 32'h40000000);
      repeat (LAT + 1) next_cyc();
      @(negedge clk);
      chk("add_rsp_v", 32'(rsp_valid), 32'h1);
      chk("add_rsp_d", rsp_data, 32'h40400000);

      // Subtract from requester 2.
      next_cyc();
      set_req(2, 32'h40400000, 32'h3F800000, 1'b1);
      req_valid = 4'b0100;
      @(negedge clk) chk("sub_ready", 32'(req_ready), 32'h4);
      next_cyc();
      req_valid = '0;
      @(negedge clk) chk("sub_issue_b", add_b, 32'hBF800000);
      repeat (LAT + 1) next_cyc();
      @(negedge clk);
      chk("sub_rsp_v", 32'(rsp_valid), 32'h4);
      chk("sub_rsp_d", rsp_data, 32'h40000000);

      // Pointer at 3, requesters 1 and 3 valid.
      next_cyc();
      set_req(1, rnd_fp(), rnd_fp(), 1'b0);
      set_req(3, rnd_fp(), rnd_fp(), 1'b1);
      req_valid = 4'b1010;
      @(negedge clk) chk("wrap_g3", 32'(req_ready), 32'h8);
      next_cyc();
      @(negedge clk) chk("wrap_g1", 32'(req_ready), 32'h2);
      next_cyc();
      set_req(0, rnd_fp(), rnd_fp(), 1'b0);
      set_req(2, rnd_fp(), rnd_fp(), 1'b0);
      req_valid = 4'b1111;
      @(negedge clk) chk("wrap_ptr2", 32'(req_ready), 32'h4);
      next_cyc();
      req_valid = 4'b1000;
      @(negedge clk) chk("wrap_g3b", 32'(req_ready), 32'h8);
      next_cyc();
      req_valid = '0;
      repeat (LAT + 3) next_cyc();

      // Fairness: all four held for 8 cycles.
      for (int i = 0; i < N; i++) set_req(i, rnd_fp(), rnd_fp(), 1'($urandom));
      req_valid = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk) chk("rr_grant", 32'(req_ready), 32'(1) << (i % 4));
         next_cyc();
      end
      req_valid = '0;
      repeat (LAT + 1) next_cyc();
      @(negedge clk);
      chk("rr_last_rsp", 32'(rsp_valid), 32'h8);
      chk("rr_busy_last", 32'(busy), 32'h1);
      next_cyc();
      @(negedge clk) chk("rr_busy_done", 32'(busy), 32'h0);

      // Reset one cycle after the third issue.
      next_cyc();
      for (int i = 0; i < 3; i++) set_req(i, rnd_fp(), rnd_fp(), 1'($urandom));
      req_valid = 4'b0111;
      repeat (3) next_cyc();
      req_valid = '0;
      next_cyc();
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_av", 32'(add_valid), 32'h0);
      chk("mid_rst_busy", 32'(busy), 32'h0);
      chk("mid_rst_a", add_a, 32'h0);
      repeat (2) next_cyc();
      rst_n = 1'b1;
      repeat (LAT + 3) next_cyc();
      set_req(1, 32'h3F800000, 32'h3F800000, 1'b0);
      req_valid = 4'b0010;
      @(negedge clk) chk("post_rst_ready", 32'(req_ready), 32'h2);
      next_cyc();
      req_valid = '0;
      repeat (LAT + 1) next_cyc();
      @(negedge clk);
      chk("post_rst_rsp_v", 32'(rsp_valid), 32'h2);
      chk("post_rst_rsp_d", rsp_data, 32'h40000000);

      // Idle.
      next_cyc();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_ready", 32'(req_ready), 32'h0);
         chk("idle_busy", 32'(busy), 32'h0);
         next_cyc();
      end

      // Randomized traffic.
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) set_req(i, rnd_fp(), rnd_fp(), 1'($urandom));
         req_valid = N'($urandom);
         next_cyc();
      end
      req_valid = '0;
      repeat (LAT + 4) next_cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
